// File: rtl/controlador_ampliacao_if.sv
// Signal bundle between the upscaler controller, the source memory, the pixel
// replicator and the output framebuffer.
interface controlador_ampliacao_if #(
  parameter int LARGURA_IMAGEM = 4,
  parameter int ALTURA_IMAGEM  = 4,
  parameter int LARGURA_PIXEL  = 8
);
  localparam int AW_RD = $clog2(LARGURA_IMAGEM * ALTURA_IMAGEM);
  localparam int AW_WR = $clog2(4 * LARGURA_IMAGEM * ALTURA_IMAGEM);

  logic                     start;
  logic                     busy;
  logic                     done;
  logic                     erro;
  logic                     rd_en;
  logic [AW_RD-1:0]         rd_addr;
  logic [LARGURA_PIXEL-1:0] rd_data;
  logic                     rep_valid;
  logic [LARGURA_PIXEL-1:0] rep_pixel;
  logic                     rep_out_valid;
  logic [LARGURA_PIXEL-1:0] rep_out_pixel;
  logic                     wr_en;
  logic [AW_WR-1:0]         wr_addr;
  logic [LARGURA_PIXEL-1:0] wr_data;

  // Controller side.
  modport master (
    input  start, rd_data, rep_out_valid, rep_out_pixel,
    output busy, done, erro, rd_en, rd_addr, rep_valid, rep_pixel,
           wr_en, wr_addr, wr_data
  );

  // Environment side: memories, replicator and frame requester.
  modport slave (
    output start, rd_data, rep_out_valid, rep_out_pixel,
    input  busy, done, erro, rd_en, rd_addr, rep_valid, rep_pixel,
           wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/controlador_ampliacao.sv
// 2x upscale controller: streams each source row into the pixel replicator and
// writes the two replicated output rows it returns into the output framebuffer.
module controlador_ampliacao #(
  parameter int LARGURA_IMAGEM = 4,
  parameter int ALTURA_IMAGEM  = 4,
  parameter int LARGURA_PIXEL  = 8
) (
  input logic clk,
  input logic resetn,
  controlador_ampliacao_if.master bus
);
  localparam int AW_RD = $clog2(LARGURA_IMAGEM * ALTURA_IMAGEM);
  localparam int AW_WR = $clog2(4 * LARGURA_IMAGEM * ALTURA_IMAGEM);
  localparam int CW    = $clog2(LARGURA_IMAGEM);
  localparam int LW    = (ALTURA_IMAGEM > 1) ? $clog2(ALTURA_IMAGEM) : 1;
  localparam int BW    = $clog2(4 * LARGURA_IMAGEM);

  localparam logic [CW-1:0] COL_ULT    = CW'(LARGURA_IMAGEM - 1);
  localparam logic [LW-1:0] LIN_ULT    = LW'(ALTURA_IMAGEM - 1);
  localparam logic [BW-1:0] BATIDA_ULT = BW'(4 * LARGURA_IMAGEM - 1);

  typedef enum logic [2:0] {
    IDLE,
    LER,
    DRENAR,
    AGUARDAR,
    FIM
  } estado_t;

  estado_t estado, estado_prox;

  logic [CW-1:0]            col;
  logic [LW-1:0]            linha;
  logic [BW-1:0]            cnt_batida;
  logic [AW_RD-1:0]         rd_addr_q;
  logic [AW_WR-1:0]         wr_cnt;
  logic                     erro_q;

  logic                     vld_p0;
  logic                     vld_p1;
  logic [LARGURA_PIXEL-1:0] pix_p1;
  logic                     wr_vld_p1;
  logic [LARGURA_PIXEL-1:0] wr_data_p1;
  logic [AW_WR-1:0]         wr_addr_p1;

  logic aceita;
  logic ler;
  logic ev_batida;
  logic ultima_batida;
  logic batida_fora;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) estado <= IDLE;
    else         estado <= estado_prox;
  end

  always_comb begin
    estado_prox   = estado;
    bus.busy      = 1'b1;
    bus.done      = 1'b0;
    bus.rd_en     = 1'b0;
    aceita        = 1'b0;
    ler           = 1'b0;
    ev_batida     = 1'b0;
    ultima_batida = 1'b0;
    batida_fora   = bus.rep_out_valid;
    case (estado)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) begin
          aceita      = 1'b1;
          estado_prox = LER;
        end
      end
      LER: begin
        bus.rd_en = 1'b1;
        ler       = 1'b1;
        if (col == COL_ULT) estado_prox = DRENAR;
      end
      DRENAR: begin
        // The last pixel of the row is on rep_valid when stage p0 has emptied.
        if (vld_p1 && !vld_p0) estado_prox = AGUARDAR;
      end
      AGUARDAR: begin
        batida_fora = 1'b0;
        ev_batida   = bus.rep_out_valid;
        if (bus.rep_out_valid && (cnt_batida == BATIDA_ULT)) begin
          ultima_batida = 1'b1;
          estado_prox   = (linha == LIN_ULT) ? FIM : LER;
        end
      end
      FIM: begin
        bus.done    = 1'b1;
        estado_prox = IDLE;
      end
      default: estado_prox = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      col        <= '0;
      linha      <= '0;
      cnt_batida <= '0;
      rd_addr_q  <= '0;
      wr_cnt     <= '0;
      erro_q     <= 1'b0;
    end else begin
      if (aceita) begin
        col        <= '0;
        linha      <= '0;
        cnt_batida <= '0;
        rd_addr_q  <= '0;
        wr_cnt     <= '0;
        erro_q     <= 1'b0;
      end
      // rd_addr runs row-major across the frame, so it never needs rebuilding per row.
      if (ler) begin
        rd_addr_q <= rd_addr_q + 1'b1;
        col       <= (col == COL_ULT) ? '0 : col + 1'b1;
      end
      if (ev_batida) begin
        cnt_batida <= ultima_batida ? '0 : cnt_batida + 1'b1;
        wr_cnt     <= wr_cnt + 1'b1;
      end
      if (ultima_batida && (linha != LIN_ULT)) begin
        linha <= linha + 1'b1;
        col   <= '0;
      end
      if (batida_fora) erro_q <= 1'b1;
    end
  end

  // Read stage p0: memory returns rd_data. Stage p1: pixel presented to the replicator.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      pix_p1 <= '0;
    end else begin
      vld_p0 <= bus.rd_en;
      vld_p1 <= vld_p0;
      if (vld_p0) pix_p1 <= bus.rd_data;
    end
  end

  // Write stage p1: one registered framebuffer write per accepted replicator beat.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_vld_p1  <= 1'b0;
      wr_data_p1 <= '0;
      wr_addr_p1 <= '0;
    end else begin
      wr_vld_p1 <= ev_batida;
      if (aceita) wr_addr_p1 <= '0;
      if (ev_batida) begin
        wr_data_p1 <= bus.rep_out_pixel;
        wr_addr_p1 <= wr_cnt;
      end
    end
  end

  assign bus.erro      = erro_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.rep_valid = vld_p1;
  assign bus.rep_pixel = pix_p1;
  assign bus.wr_en     = wr_vld_p1;
  assign bus.wr_data   = wr_data_p1;
  assign bus.wr_addr   = wr_addr_p1;
endmodule

// File: tb/tb_controlador_ampliacao.sv
// Bench for controlador_ampliacao: 4x4 and 4x1 instances, each with a source
// memory and a 2x pixel replicator model attached.
`timescale 1ns/1ps
module tb_controlador_ampliacao;
  localparam int W = 4;
  localparam int H = 4;
  localparam int P = 8;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  logic inj_a = 1'b0;
  logic [7:0] row_exp [8] = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h02, 8'h02, 8'h03, 8'h03};

  controlador_ampliacao_if #(.LARGURA_IMAGEM(W), .ALTURA_IMAGEM(H), .LARGURA_PIXEL(P)) bus_a ();
  controlador_ampliacao_if #(.LARGURA_IMAGEM(W), .ALTURA_IMAGEM(1), .LARGURA_PIXEL(P)) bus_b ();

  controlador_ampliacao #(.LARGURA_IMAGEM(W), .ALTURA_IMAGEM(H), .LARGURA_PIXEL(P)) dut_a (
    .clk(clk), .resetn(resetn), .bus(bus_a));
  controlador_ampliacao #(.LARGURA_IMAGEM(W), .ALTURA_IMAGEM(1), .LARGURA_PIXEL(P)) dut_b (
    .clk(clk), .resetn(resetn), .bus(bus_b));

  // Source memories: pixel value equals its address.
  always @(posedge clk) begin
    if (bus_a.rd_en) bus_a.rd_data <= P'(bus_a.rd_addr);
    if (bus_b.rd_en) bus_b.rd_data <= P'(bus_b.rd_addr);
  end

  // Replicator models: buffer W pixels, then emit 2 output rows of 2W beats.
  logic [7:0] rb_a [4];
  int ci_a = 0, k_a = 0;
  logic em_a = 1'b0;
  always @(posedge clk) begin
    if (!resetn) begin
      ci_a <= 0; k_a <= 0; em_a <= 1'b0;
    end else if (bus_a.rep_valid) begin
      rb_a[ci_a] <= bus_a.rep_pixel;
      if (ci_a == W - 1) begin ci_a <= 0; em_a <= 1'b1; k_a <= 0; end
      else ci_a <= ci_a + 1;
    end else if (em_a) begin
      if (k_a == 4 * W - 1) em_a <= 1'b0;
      k_a <= k_a + 1;
    end
  end
  assign bus_a.rep_out_valid = em_a | inj_a;
  assign bus_a.rep_out_pixel = inj_a ? 8'hEE : rb_a[(k_a % (2 * W)) / 2];

  logic [7:0] rb_b [4];
  int ci_b = 0, k_b = 0;
  logic em_b = 1'b0;
  always @(posedge clk) begin
    if (!resetn) begin
      ci_b <= 0; k_b <= 0; em_b <= 1'b0;
    end else if (bus_b.rep_valid) begin
      rb_b[ci_b] <= bus_b.rep_pixel;
      if (ci_b == W - 1) begin ci_b <= 0; em_b <= 1'b1; k_b <= 0; end
      else ci_b <= ci_b + 1;
    end else if (em_b) begin
      if (k_b == 4 * W - 1) em_b <= 1'b0;
      k_b <= k_b + 1;
    end
  end
  assign bus_b.rep_out_valid = em_b;
  assign bus_b.rep_out_pixel = rb_b[(k_b % (2 * W)) / 2];

  // Observers, sampled 1 ns after each rising edge.
  int n_rd, n_rv, n_wr, n_done, first_rd, first_rv, rv_runs, rv_lag_err, wr_follow_err;
  logic rd_d1, rd_d2, prev_rv, prev_em;
  int wr_log [256];
  logic [7:0] fb [64];
  always @(posedge clk) begin
    #1;
    if (bus_a.rd_en) begin if (n_rd == 0) first_rd = cyc; n_rd++; end
    if (bus_a.rep_valid) begin
      if (n_rv == 0) first_rv = cyc;
      if (!prev_rv) rv_runs++;
      n_rv++;
    end
    if (bus_a.rep_valid !== rd_d2) rv_lag_err++;
    if (bus_a.wr_en) begin
      if (n_wr < 256) wr_log[n_wr] = int'(bus_a.wr_addr);
      fb[bus_a.wr_addr] = bus_a.wr_data;
      n_wr++;
    end
    if (bus_a.wr_en !== prev_em) wr_follow_err++;
    if (bus_a.done) n_done++;
    rd_d2 = rd_d1; rd_d1 = bus_a.rd_en; prev_rv = bus_a.rep_valid; prev_em = em_a;
  end

  int n_rd_b, n_wr_b, n_done_b, done_cyc_b, last_beat_b;
  int wr_log_b [64];
  logic [7:0] fb_b [16];
  always @(posedge clk) begin
    #1;
    if (bus_b.rd_en) n_rd_b++;
    if (bus_b.wr_en) begin
      if (n_wr_b < 64) wr_log_b[n_wr_b] = int'(bus_b.wr_addr);
      fb_b[bus_b.wr_addr] = bus_b.wr_data;
      n_wr_b++;
    end
    if (em_b) last_beat_b = cyc;
    if (bus_b.done) begin n_done_b++; done_cyc_b = cyc; end
  end

  task automatic clear_mon_a();
    n_rd = 0; n_rv = 0; n_wr = 0; n_done = 0; first_rd = 0; first_rv = 0;
    rv_runs = 0; rv_lag_err = 0; wr_follow_err = 0;
    rd_d1 = 1'b0; rd_d2 = 1'b0; prev_rv = 1'b0; prev_em = 1'b0;
  endtask

  task automatic wait_done_a(input int limit, output bit got, output logic busy_at);
    got = 1'b0;
    busy_at = 1'b0;
    for (int i = 0; i < limit && !got; i++) begin
      @(negedge clk);
      if (bus_a.done === 1'b1) begin got = 1'b1; busy_at = bus_a.busy; end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({bus_a.busy, bus_a.done, bus_a.erro, bus_a.rd_en, bus_a.rep_valid, bus_a.wr_en} !== 6'b0)
      $display("FAIL reset_ctrl got %b want 000000",
               {bus_a.busy, bus_a.done, bus_a.erro, bus_a.rd_en, bus_a.rep_valid, bus_a.wr_en});
    else n_pass++;
    n_chk++;
    if (bus_a.rd_addr !== 4'd0 || bus_a.wr_addr !== 6'd0)
      $display("FAIL reset_addr got rd=%0d wr=%0d want 0 0", bus_a.rd_addr, bus_a.wr_addr);
    else n_pass++;
    n_chk++;
    if (bus_a.rep_pixel !== 8'h00 || bus_a.wr_data !== 8'h00)
      $display("FAIL reset_data got rep=%h wr=%h want 00 00", bus_a.rep_pixel, bus_a.wr_data);
    else n_pass++;
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if (bus_a.busy !== 1'b0 || bus_b.busy !== 1'b0)
      $display("FAIL idle_after_reset got busy a=%b b=%b want 0 0", bus_a.busy, bus_b.busy);
    else n_pass++;
  endtask

  task automatic test_frame(input string tag);
    bit got;
    logic busy_at;
    int errs;
    clear_mon_a();
    @(negedge clk); bus_a.start = 1'b1;
    @(negedge clk); bus_a.start = 1'b0;
    n_chk++;
    if (bus_a.busy !== 1'b1) $display("FAIL %s_busy_mid got %b want 1", tag, bus_a.busy);
    else n_pass++;
    wait_done_a(400, got, busy_at);
    n_chk++;
    if (!got) $display("FAIL %s_done_timeout got no done want done within 400 cycles", tag);
    else n_pass++;
    n_chk++;
    if (busy_at !== 1'b1) $display("FAIL %s_busy_at_done got %b want 1", tag, busy_at);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (bus_a.busy !== 1'b0 || bus_a.done !== 1'b0)
      $display("FAIL %s_after_done got busy=%b done=%b want 0 0", tag, bus_a.busy, bus_a.done);
    else n_pass++;
    n_chk++;
    if (n_rd !== 16 || n_rv !== 16 || n_wr !== 64)
      $display("FAIL %s_counts got rd=%0d rv=%0d wr=%0d want 16 16 64", tag, n_rd, n_rv, n_wr);
    else n_pass++;
    n_chk++;
    if (n_done !== 1) $display("FAIL %s_done_count got %0d want 1", tag, n_done);
    else n_pass++;
    errs = 0;
    for (int i = 0; i < 64; i++) if (wr_log[i] != i) errs++;
    n_chk++;
    if (errs != 0) $display("FAIL %s_wr_addr_seq got %0d bad addresses want 0 (first=%0d)", tag, errs, wr_log[0]);
    else n_pass++;
    errs = 0;
    for (int k = 0; k < 8; k++) begin
      if (fb[k] !== row_exp[k]) errs++;
      if (fb[8 + k] !== row_exp[k]) errs++;
    end
    n_chk++;
    if (errs != 0) $display("FAIL %s_rows01 got %0d bad pixels (fb0=%h fb8=%h) want 00 00 01 01 02 02 03 03", tag, errs, fb[0], fb[8]);
    else n_pass++;
    errs = 0;
    for (int a = 0; a < 64; a++) if (fb[a] !== 8'((a / 16) * 4 + (a % 8) / 2)) errs++;
    n_chk++;
    if (errs != 0) $display("FAIL %s_frame_pixels got %0d bad pixels want 0", tag, errs);
    else n_pass++;
    n_chk++;
    if (first_rv - first_rd !== 2) $display("FAIL %s_rep_latency got %0d want 2", tag, first_rv - first_rd);
    else n_pass++;
    n_chk++;
    if (rv_lag_err !== 0 || rv_runs !== 4)
      $display("FAIL %s_rep_valid_shape got lag_err=%0d runs=%0d want 0 4", tag, rv_lag_err, rv_runs);
    else n_pass++;
    n_chk++;
    if (wr_follow_err !== 0) $display("FAIL %s_wr_latency got %0d mismatched cycles want 0", tag, wr_follow_err);
    else n_pass++;
    n_chk++;
    if (bus_a.erro !== 1'b0) $display("FAIL %s_erro got %b want 0", tag, bus_a.erro);
    else n_pass++;
  endtask

  task automatic test_start_held();
    bit got;
    logic busy_at;
    clear_mon_a();
    @(negedge clk); bus_a.start = 1'b1;
    wait_done_a(400, got, busy_at);
    n_chk++;
    if (!got || n_done !== 1 || n_wr !== 64)
      $display("FAIL held_first_frame got done=%b n_done=%0d n_wr=%0d want 1 1 64", got, n_done, n_wr);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (bus_a.busy !== 1'b0) $display("FAIL held_idle_after_fim got busy=%b want 0", bus_a.busy);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (bus_a.busy !== 1'b1 || bus_a.rd_en !== 1'b1 || bus_a.rd_addr !== 4'd0)
      $display("FAIL held_second_start got busy=%b rd_en=%b rd_addr=%0d want 1 1 0",
               bus_a.busy, bus_a.rd_en, bus_a.rd_addr);
    else n_pass++;
    bus_a.start = 1'b0;
    wait_done_a(400, got, busy_at);
    n_chk++;
    if (!got || n_done !== 2 || n_wr !== 128)
      $display("FAIL held_second_frame got done=%b n_done=%0d n_wr=%0d want 1 2 128", got, n_done, n_wr);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_inject();
    bit got;
    logic busy_at;
    int errs;
    clear_mon_a();
    @(negedge clk); bus_a.start = 1'b1;
    @(negedge clk); bus_a.start = 1'b0;
    inj_a = bus_a.rd_en;
    @(negedge clk); inj_a = 1'b0;
    n_chk++;
    if (bus_a.erro !== 1'b1 || bus_a.wr_en !== 1'b0 || n_wr !== 0)
      $display("FAIL inject_effect got erro=%b wr_en=%b n_wr=%0d want 1 0 0", bus_a.erro, bus_a.wr_en, n_wr);
    else n_pass++;
    wait_done_a(400, got, busy_at);
    errs = 0;
    for (int i = 0; i < 64; i++) if (wr_log[i] != i) errs++;
    n_chk++;
    if (!got || n_wr !== 64 || errs != 0)
      $display("FAIL inject_frame got done=%b n_wr=%0d bad_addr=%0d want 1 64 0", got, n_wr, errs);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (bus_a.erro !== 1'b1) $display("FAIL inject_sticky got erro=%b want 1", bus_a.erro);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit got;
    clear_mon_a();
    @(negedge clk); bus_a.start = 1'b1;
    @(negedge clk); bus_a.start = 1'b0;
    n_chk++;
    if (bus_a.erro !== 1'b0) $display("FAIL erro_clear_on_start got %b want 0", bus_a.erro);
    else n_pass++;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (bus_a.wr_en === 1'b1 && bus_a.wr_addr === 6'd36) got = 1'b1;
    end
    n_chk++;
    if (!got) $display("FAIL midreset_reach_row2 got no write to 36 want write within 300 cycles");
    else n_pass++;
    resetn = 1'b0;
    #1;
    n_chk++;
    if ({bus_a.busy, bus_a.done, bus_a.erro, bus_a.rd_en, bus_a.rep_valid, bus_a.wr_en} !== 6'b0 ||
        bus_a.wr_addr !== 6'd0 || bus_a.rd_addr !== 4'd0 || bus_a.wr_data !== 8'h00)
      $display("FAIL midreset_async got ctrl=%b wr_addr=%0d rd_addr=%0d want all 0",
               {bus_a.busy, bus_a.done, bus_a.erro, bus_a.rd_en, bus_a.rep_valid, bus_a.wr_en},
               bus_a.wr_addr, bus_a.rd_addr);
    else n_pass++;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if (n_done !== 0 || bus_a.busy !== 1'b0)
      $display("FAIL midreset_no_done got n_done=%0d busy=%b want 0 0", n_done, bus_a.busy);
    else n_pass++;
  endtask

  task automatic test_h1();
    bit got;
    int errs;
    n_rd_b = 0; n_wr_b = 0; n_done_b = 0; done_cyc_b = 0; last_beat_b = 0;
    @(negedge clk); bus_b.start = 1'b1;
    @(negedge clk); bus_b.start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (bus_b.done === 1'b1) got = 1'b1;
    end
    n_chk++;
    if (!got) $display("FAIL h1_done_timeout got no done want done within 100 cycles");
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (n_rd_b !== 4 || n_wr_b !== 16 || n_done_b !== 1)
      $display("FAIL h1_counts got rd=%0d wr=%0d done=%0d want 4 16 1", n_rd_b, n_wr_b, n_done_b);
    else n_pass++;
    errs = 0;
    for (int i = 0; i < 16; i++) begin
      if (wr_log_b[i] != i) errs++;
      if (fb_b[i] !== 8'((i % 8) / 2)) errs++;
    end
    n_chk++;
    if (errs != 0) $display("FAIL h1_addr_data got %0d errors want 0", errs);
    else n_pass++;
    n_chk++;
    if (done_cyc_b - last_beat_b !== 1)
      $display("FAIL h1_done_timing got %0d cycles after 16th write beat want 1", done_cyc_b - last_beat_b);
    else n_pass++;
  endtask

  initial begin
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    test_reset();
    test_frame("frame");
    test_start_held();
    test_inject();
    test_reset_mid();
    test_frame("after_reset");
    test_h1();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
